memory_arbiter_multi: RTL

Parametrised successor to the two-port memory arbiter. Serialises line-sized read/write requests from `NUM_CH` requesters (i-cache, d-cache, TLB walker, DMA, ...) onto one fixed-latency main-memory array with round-robin or fixed-priority arbitration. Sits between the cache/TLB refill logic and main memory, replacing the hard-wired i/d arbiter in the CPU top level.

---
 rtl/memory_arbiter_multi.sv | 130 +++++++++++++
 1 files changed

// File: rtl/memory_arbiter_multi.sv
// Multi-channel line arbiter: serialises NUM_CH line requests onto one
// fixed-latency backing array with round-robin or fixed-priority grants.
module memory_arbiter_multi #(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 20,
    parameter int LINE_W    = 128,
    parameter int MEM_LINES = 1024,
    parameter int LATENCY   = 5,
    parameter int PRIO_MODE = 0
) (
    input  logic                      clock,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         enable,
    input  logic [NUM_CH-1:0]         write_or_read,
    input  logic [NUM_CH*ADDR_W-1:0]  address,
    input  logic [NUM_CH*LINE_W-1:0]  in_data,
    output logic [NUM_CH*LINE_W-1:0]  out_data,
    output logic [NUM_CH-1:0]         ready,
    output logic                      busy,
    output logic [$clog2(NUM_CH)-1:0] grant_id
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int CNT_W = $clog2(LATENCY);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_p0, state_nxt;
    logic [CNT_W-1:0]  cnt_p0;
    logic [CH_W-1:0]   last_p0;
    logic [CH_W-1:0]   gid_p0;
    logic              wr_p0;
    logic [IDX_W-1:0]  idx_p0;
    logic [LINE_W-1:0] wdata_p0;
    logic [LINE_W-1:0] rdata_p1 [NUM_CH];
    logic [LINE_W-1:0] mem [MEM_LINES];

    logic [IDX_W-1:0]  idx_a [NUM_CH];
    logic [LINE_W-1:0] din_a [NUM_CH];
    logic [CH_W-1:0]   winner;
    logic [CH_W-1:0]   cand;
    logic              grant;
    logic              access;
    logic              addr_unused;

    // Offset bits inside a line and aliasing upper bits are dropped here.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign idx_a[g] = address[g*ADDR_W + OFF_W +: IDX_W];
        assign din_a[g] = in_data[g*LINE_W +: LINE_W];
        assign out_data[g*LINE_W +: LINE_W] = rdata_p1[g];
    end
    assign addr_unused = ^address;

    always_comb begin
        winner = '0;
        cand   = '0;
        if (PRIO_MODE == 1) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                cand = CH_W'(i);
                if (enable[cand]) winner = cand;
            end
        end else begin
            // Walk backwards so the channel closest after last_p0 wins.
            for (int k = NUM_CH; k >= 1; k--) begin
                cand = CH_W'((int'(last_p0) + k) % NUM_CH);
                if (enable[cand]) winner = cand;
            end
        end
    end

    assign grant  = (state_p0 == IDLE) && (|enable);
    assign access = (state_p0 == BUSY) && (cnt_p0 == '0);

    always_comb begin
        state_nxt = state_p0;
        case (state_p0)
            IDLE:    if (|enable) state_nxt = BUSY;
            BUSY:    if (cnt_p0 == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) state_p0 <= IDLE;
        else      state_p0 <= state_nxt;
    end

    // Stage p0: grant-time control
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            cnt_p0  <= '0;
            last_p0 <= CH_W'(NUM_CH - 1);
            gid_p0  <= '0;
        end else if (grant) begin
            cnt_p0  <= CNT_W'(LATENCY - 2);
            last_p0 <= winner;
            gid_p0  <= winner;
        end else if (state_p0 == BUSY && cnt_p0 != '0) begin
            cnt_p0  <= cnt_p0 - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (grant) begin
            wr_p0    <= write_or_read[winner];
            idx_p0   <= idx_a[winner];
            wdata_p0 <= din_a[winner];
        end
    end

    // Stage p1: array access on the BUSY->DONE edge
    always_ff @(posedge clock) begin
        if (access && wr_p0) mem[idx_p0] <= wdata_p0;
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) rdata_p1[i] <= '0;
        end else if (access && !wr_p0) begin
            rdata_p1[gid_p0] <= mem[idx_p0];
        end
    end

    assign busy     = (state_p0 != IDLE);
    assign grant_id = gid_p0;
    assign ready    = (state_p0 == DONE) ? ({{(NUM_CH-1){1'b0}}, 1'b1} << gid_p0) : '0;

endmodule
